// File: rtl/orc_mem_pkg.sv
// ---------------------------------------------------------------------------
// orc_mem_pkg
// Shared definitions for the ORC_R32I memory-side slave.
//   CONSOLE_ADDR / MEM_BASE / MEM_BYTES : default address map
//   gnt_e                               : which port owns the current grant
//   tgt_e                               : where a decoded address lands
//   in_window / is_console / decode_addr: address decode helpers
// ---------------------------------------------------------------------------
package orc_mem_pkg;

    localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
    localparam logic [31:0] MEM_BASE     = 32'h0000_0000;
    localparam int unsigned MEM_BYTES    = 262144;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2,
        GNT_IF   = 2'd3
    } gnt_e;

    typedef enum logic [1:0] {
        TGT_MEM     = 2'd0,
        TGT_CONSOLE = 2'd1,
        TGT_NONE    = 2'd2
    } tgt_e;

    // Unsigned offset compare also rejects addresses below the base,
    // because the subtraction wraps to a large value.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] bytes);
        logic [31:0] off;
        off = addr - base;
        return (off < bytes);
    endfunction

    function automatic logic is_console(input logic [31:0] addr,
                                        input logic [31:0] console_addr);
        return (addr == console_addr);
    endfunction

    // Console wins over the SRAM window so the console register stays
    // reachable even if someone maps the window on top of it.
    function automatic tgt_e decode_addr(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] bytes,
                                         input logic [31:0] console_addr);
        if (is_console(addr, console_addr))
            return TGT_CONSOLE;
        else if (in_window(addr, base, bytes))
            return TGT_MEM;
        else
            return TGT_NONE;
    endfunction

endpackage

// File: rtl/orc_console_fifo.sv
// ---------------------------------------------------------------------------
// orc_console_fifo
// Small synchronous FIFO buffering console TX bytes.
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_push, i_push_data   : write side; accepted when not full, or when full
//                           and a pop happens in the same cycle
//   o_full                : no free entry (pop-in-same-cycle not counted)
//   o_valid, i_ready      : read side; pop on o_valid & i_ready
//   o_data                : head entry
// ---------------------------------------------------------------------------
module orc_console_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_full,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] storage [DEPTH];

    // One extra pointer bit tells full from empty when the indices match.
    logic [PW:0] wr_ptr_q;
    logic [PW:0] rd_ptr_q;
    logic        pop;
    logic        push_ok;

    assign o_valid = (wr_ptr_q != rd_ptr_q);
    assign o_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign o_data  = storage[rd_ptr_q[PW-1:0]];

    assign pop     = o_valid & i_ready;
    // The slot freed by a simultaneous pop can take the new byte.
    assign push_ok = i_push & (~o_full | pop);

    // NOTE: storage has no reset; the pointers alone decide what is valid,
    // so clearing the array would only cost reset fan-out.
    always_ff @(posedge i_clk) begin
        if (push_ok)
            storage[wr_ptr_q[PW-1:0]] <= i_push_data;
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

endmodule

// File: rtl/orc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// orc_mem_arbiter
// Memory-side slave for the ORC_R32I core. Three strobe/ack request ports
// (data write, data read, instruction fetch) share one synchronous
// single-port SRAM; writes to the console address feed a byte FIFO.
//   i_clk, i_reset                       : clock, async active-high reset
//   i_inst_read_*  / o_inst_read_*       : fetch port
//   i_master_read_* / o_master_read_*    : data read port
//   i_master_write_* / o_master_write_ack: data write port
//   o_mem_en/we/addr/wdata, i_mem_rdata  : SRAM (read data one cycle later)
//   o_console_valid/data, i_console_ready: console byte stream
// A request granted in cycle N is acked in N+1 with its data.
// Priority is write > data read > fetch, one grant per cycle.
// ---------------------------------------------------------------------------
module orc_mem_arbiter
    import orc_mem_pkg::*;
#(
    parameter  logic [31:0] P_MEM_BASE      = MEM_BASE,
    parameter  int unsigned P_MEM_BYTES     = MEM_BYTES,
    parameter  logic [31:0] P_CONSOLE_ADDR  = CONSOLE_ADDR,
    parameter  int unsigned P_CONSOLE_DEPTH = 8,
    localparam int unsigned AW              = $clog2(P_MEM_BYTES / 4)
) (
    input  logic          i_clk,
    input  logic          i_reset,

    input  logic          i_inst_read_stb,
    output logic          o_inst_read_ack,
    input  logic [31:0]   i_inst_read_addr,
    output logic [31:0]   o_inst_read_data,

    input  logic          i_master_read_stb,
    output logic          o_master_read_ack,
    input  logic [31:0]   i_master_read_addr,
    output logic [31:0]   o_master_read_data,

    input  logic          i_master_write_stb,
    output logic          o_master_write_ack,
    input  logic [31:0]   i_master_write_addr,
    input  logic [31:0]   i_master_write_data,
    input  logic [3:0]    i_master_write_sel,

    output logic          o_mem_en,
    output logic [3:0]    o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata,

    output logic          o_console_valid,
    input  logic          i_console_ready,
    output logic [7:0]    o_console_data
);

    localparam logic [31:0] MEM_BYTES_W = 32'(P_MEM_BYTES);

    // Request tracking
    logic wr_pend_q, rd_pend_q, if_pend_q;
    logic wr_req, rd_req, if_req;
    tgt_e wr_tgt, rd_tgt, if_tgt;
    logic wr_blocked;

    // Grant and SRAM request
    gnt_e        gnt;
    gnt_e        gnt_q;
    logic        from_mem_q;
    logic [31:0] mem_byte_addr;
    logic [31:0] mem_off;
    logic        unused_mem_off;

    // Response data
    logic [31:0] rd_imm, if_imm;
    logic [31:0] rd_data_q, if_data_q;

    // Console FIFO
    logic fifo_full;
    logic fifo_push;

    // -----------------------------------------------------------------------
    // Decode and arbitration
    // -----------------------------------------------------------------------
    assign wr_req = wr_pend_q | i_master_write_stb;
    assign rd_req = rd_pend_q | i_master_read_stb;
    assign if_req = if_pend_q | i_inst_read_stb;

    assign wr_tgt = decode_addr(i_master_write_addr, P_MEM_BASE, MEM_BYTES_W, P_CONSOLE_ADDR);
    assign rd_tgt = decode_addr(i_master_read_addr,  P_MEM_BASE, MEM_BYTES_W, P_CONSOLE_ADDR);
    assign if_tgt = decode_addr(i_inst_read_addr,    P_MEM_BASE, MEM_BYTES_W, P_CONSOLE_ADDR);

    // A full FIFO with the sink ready frees a slot this cycle, so the
    // console write can go through alongside the pop.
    assign wr_blocked = (wr_tgt == TGT_CONSOLE) && fifo_full && !i_console_ready;

    // NOTE: every always_comb output gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        gnt = GNT_NONE;
        if (!i_reset) begin
            // A blocked console write holds the bus: lower ports must wait
            // behind it rather than overtake a write still in order.
            if (wr_req) begin
                if (!wr_blocked)
                    gnt = GNT_WR;
            end else if (rd_req) begin
                gnt = GNT_RD;
            end else if (if_req) begin
                gnt = GNT_IF;
            end
        end
    end

    // -----------------------------------------------------------------------
    // SRAM request for the granted port
    // -----------------------------------------------------------------------
    always_comb begin
        o_mem_en      = 1'b0;
        o_mem_we      = 4'b0000;
        mem_byte_addr = i_master_write_addr;
        unique case (gnt)
            GNT_WR: begin
                mem_byte_addr = i_master_write_addr;
                if (wr_tgt == TGT_MEM) begin
                    o_mem_en = 1'b1;
                    o_mem_we = i_master_write_sel;
                end
            end
            GNT_RD: begin
                mem_byte_addr = i_master_read_addr;
                o_mem_en      = (rd_tgt == TGT_MEM);
            end
            GNT_IF: begin
                mem_byte_addr = i_inst_read_addr;
                o_mem_en      = (if_tgt == TGT_MEM);
            end
            default: ;
        endcase
    end

    assign mem_off        = mem_byte_addr - P_MEM_BASE;
    assign o_mem_addr     = mem_off[AW+1:2];
    assign o_mem_wdata    = i_master_write_data;
    // Byte-lane and out-of-window bits of the offset are not needed.
    assign unused_mem_off = ^mem_off;

    // Data returned without an SRAM cycle: console status or zero.
    assign rd_imm = (rd_tgt == TGT_CONSOLE) ? {31'b0, fifo_full} : 32'h0;
    assign if_imm = (if_tgt == TGT_CONSOLE) ? {31'b0, fifo_full} : 32'h0;

    assign fifo_push = (gnt == GNT_WR) && (wr_tgt == TGT_CONSOLE);

    // -----------------------------------------------------------------------
    // Pending flags, registered grant and response capture
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            if_pend_q  <= 1'b0;
            gnt_q      <= GNT_NONE;
            from_mem_q <= 1'b0;
            rd_data_q  <= 32'h0;
            if_data_q  <= 32'h0;
        end else begin
            wr_pend_q  <= wr_req && (gnt != GNT_WR);
            rd_pend_q  <= rd_req && (gnt != GNT_RD);
            if_pend_q  <= if_req && (gnt != GNT_IF);
            gnt_q      <= gnt;
            from_mem_q <= o_mem_en;

            // Immediate data is captured at grant; SRAM data is captured
            // at ack so the output holds after the ack cycle.
            if (gnt == GNT_RD && rd_tgt != TGT_MEM)
                rd_data_q <= rd_imm;
            else if (gnt_q == GNT_RD && from_mem_q)
                rd_data_q <= i_mem_rdata;

            if (gnt == GNT_IF && if_tgt != TGT_MEM)
                if_data_q <= if_imm;
            else if (gnt_q == GNT_IF && from_mem_q)
                if_data_q <= i_mem_rdata;
        end
    end

    assign o_master_write_ack = (gnt_q == GNT_WR);
    assign o_master_read_ack  = (gnt_q == GNT_RD);
    assign o_inst_read_ack    = (gnt_q == GNT_IF);

    // SRAM data is only valid in the ack cycle, so route it straight through.
    assign o_master_read_data = (o_master_read_ack && from_mem_q) ? i_mem_rdata : rd_data_q;
    assign o_inst_read_data   = (o_inst_read_ack   && from_mem_q) ? i_mem_rdata : if_data_q;

    // -----------------------------------------------------------------------
    // Console FIFO
    // -----------------------------------------------------------------------
    orc_console_fifo #(
        .WIDTH (8),
        .DEPTH (P_CONSOLE_DEPTH)
    ) u_console_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (fifo_push),
        .i_push_data (i_master_write_data[7:0]),
        .o_full      (fifo_full),
        .o_valid     (o_console_valid),
        .i_ready     (i_console_ready),
        .o_data      (o_console_data)
    );

    // -----------------------------------------------------------------------
    // Protocol checks: a strobe while that port is still pending is ignored
    // by the logic above and reported here.
    // -----------------------------------------------------------------------
    a_wr_stb_while_pending: assert property (@(posedge i_clk) disable iff (i_reset)
        !(wr_pend_q && i_master_write_stb));
    a_rd_stb_while_pending: assert property (@(posedge i_clk) disable iff (i_reset)
        !(rd_pend_q && i_master_read_stb));
    a_if_stb_while_pending: assert property (@(posedge i_clk) disable iff (i_reset)
        !(if_pend_q && i_inst_read_stb));

endmodule

// File: tb/tb_orc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_orc_mem_arbiter
// Scoreboard bench: each scenario pushes the acks it expects (port, data,
// cycle) and a negedge monitor pops and compares as acks appear.
// ---------------------------------------------------------------------------
module tb_orc_mem_arbiter;
    import orc_mem_pkg::*;

    localparam int          AW      = 16;
    localparam logic [31:0] CONS    = 32'h1000_0000;
    localparam int          BUDGET  = 40;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_inst_read_stb = 1'b0;
    logic          o_inst_read_ack;
    logic [31:0]   i_inst_read_addr = 32'h0;
    logic [31:0]   o_inst_read_data;
    logic          i_master_read_stb = 1'b0;
    logic          o_master_read_ack;
    logic [31:0]   i_master_read_addr = 32'h0;
    logic [31:0]   o_master_read_data;
    logic          i_master_write_stb = 1'b0;
    logic          o_master_write_ack;
    logic [31:0]   i_master_write_addr = 32'h0;
    logic [31:0]   i_master_write_data = 32'h0;
    logic [3:0]    i_master_write_sel = 4'h0;
    logic          o_mem_en;
    logic [3:0]    o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [31:0]   i_mem_rdata = 32'h0;
    logic          o_console_valid;
    logic          i_console_ready = 1'b0;
    logic [7:0]    o_console_data;

    orc_mem_arbiter dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_inst_read_stb     (i_inst_read_stb),
        .o_inst_read_ack     (o_inst_read_ack),
        .i_inst_read_addr    (i_inst_read_addr),
        .o_inst_read_data    (o_inst_read_data),
        .i_master_read_stb   (i_master_read_stb),
        .o_master_read_ack   (o_master_read_ack),
        .i_master_read_addr  (i_master_read_addr),
        .o_master_read_data  (o_master_read_data),
        .i_master_write_stb  (i_master_write_stb),
        .o_master_write_ack  (o_master_write_ack),
        .i_master_write_addr (i_master_write_addr),
        .i_master_write_data (i_master_write_data),
        .i_master_write_sel  (i_master_write_sel),
        .o_mem_en            (o_mem_en),
        .o_mem_we            (o_mem_we),
        .o_mem_addr          (o_mem_addr),
        .o_mem_wdata         (o_mem_wdata),
        .i_mem_rdata         (i_mem_rdata),
        .o_console_valid     (o_console_valid),
        .i_console_ready     (i_console_ready),
        .o_console_data      (o_console_data)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural synchronous SRAM, read data one cycle after enable.
    logic [31:0] sram [0:65535];
    always @(posedge i_clk) begin
        if (o_mem_en) begin
            for (int b = 0; b < 4; b++)
                if (o_mem_we[b])
                    sram[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
            i_mem_rdata <= sram[o_mem_addr];
        end
    end

    typedef struct {
        gnt_e        port;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    resp_t       exp_q[$];
    logic [7:0]  cons_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          mem_en_cnt = 0;
    int          ack_seen = 0;
    resp_t       got;
    resp_t       want;
    int          n_acks;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Scoreboard monitor: pops one expected response per observed ack.
    always @(negedge i_clk) begin
        if (o_mem_en)
            mem_en_cnt++;
        if (o_console_valid && i_console_ready)
            cons_q.push_back(o_console_data);
        n_acks = int'(o_master_write_ack) + int'(o_master_read_ack) + int'(o_inst_read_ack);
        if (n_acks > 0) begin
            ack_seen++;
            got.cyc = cyc;
            if (o_master_write_ack) begin
                got.port = GNT_WR;
                got.data = 32'h0;
            end else if (o_master_read_ack) begin
                got.port = GNT_RD;
                got.data = o_master_read_data;
            end else begin
                got.port = GNT_IF;
                got.data = o_inst_read_data;
            end
            checks++;
            if (n_acks > 1) begin
                failures++;
                $display("FAIL ack_onehot: %0d acks in cycle %0d, required 1", n_acks, cyc);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack: port=%s data=%h cycle=%0d, required no ack",
                         got.port.name(), got.data, got.cyc);
            end else begin
                want = exp_q.pop_front();
                if (got.port !== want.port || got.data !== want.data || got.cyc != want.cyc) begin
                    failures++;
                    $display("FAIL ack_%s: got port=%s data=%h cycle=%0d, required port=%s data=%h cycle=%0d",
                             want.port.name(), got.port.name(), got.data, got.cyc,
                             want.port.name(), want.data, want.cyc);
                end
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic expect_ack(input gnt_e port, input logic [31:0] data, input int at);
        resp_t r;
        r.port = port;
        r.data = data;
        r.cyc  = at;
        exp_q.push_back(r);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        i_reset = 1'b1;
        #3;
        checks++;
        if ({o_master_write_ack, o_master_read_ack, o_inst_read_ack} !== 3'b000) begin
            failures++;
            $display("FAIL reset_acks: %b, required 000",
                     {o_master_write_ack, o_master_read_ack, o_inst_read_ack});
        end
        checks++;
        if (o_mem_en !== 1'b0 || o_mem_we !== 4'h0) begin
            failures++;
            $display("FAIL reset_mem: en=%b we=%h, required 0/0", o_mem_en, o_mem_we);
        end
        checks++;
        if (o_console_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_console_valid: %b, required 0", o_console_valid);
        end
        checks++;
        if (o_master_read_data !== 32'h0 || o_inst_read_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_read_data: rd=%h if=%h, required 0/0",
                     o_master_read_data, o_inst_read_data);
        end
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        sram[32'h0001_0000 >> 2] = 32'h0000_0013;
        tick();
        i_inst_read_addr = 32'h0001_0000;
        i_inst_read_stb  = 1'b1;
        expect_ack(GNT_IF, 32'h0000_0013, cyc + 1);
        tick();
        i_inst_read_stb  = 1'b0;
        wait_drain(BUDGET);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL fetch_timeout: %0d acks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_priority();
        tick();
        i_master_write_addr = 32'h0001_0100;
        i_master_write_data = 32'hDEAD_BEEF;
        i_master_write_sel  = 4'hF;
        i_master_read_addr  = 32'h0001_0100;
        i_inst_read_addr    = 32'h0001_0000;
        i_master_write_stb  = 1'b1;
        i_master_read_stb   = 1'b1;
        i_inst_read_stb     = 1'b1;
        expect_ack(GNT_WR, 32'h0, cyc + 1);
        expect_ack(GNT_RD, 32'hDEAD_BEEF, cyc + 2);
        expect_ack(GNT_IF, 32'h0000_0013, cyc + 3);
        tick();
        i_master_write_stb = 1'b0;
        i_master_read_stb  = 1'b0;
        i_inst_read_stb    = 1'b0;
        wait_drain(BUDGET);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL priority_timeout: %0d acks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (sram[32'h0001_0100 >> 2] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL priority_sram: %h, required deadbeef", sram[32'h0001_0100 >> 2]);
        end
    endtask

    task automatic test_byte_enable();
        sram[32'h0001_0200 >> 2] = 32'h1122_3344;
        tick();
        i_master_write_addr = 32'h0001_0200;
        i_master_write_data = 32'h0000_AB00;
        i_master_write_sel  = 4'b0010;
        i_master_write_stb  = 1'b1;
        expect_ack(GNT_WR, 32'h0, cyc + 1);
        tick();
        i_master_write_stb  = 1'b0;
        wait_drain(BUDGET);
        i_master_read_addr  = 32'h0001_0200;
        i_master_read_stb   = 1'b1;
        expect_ack(GNT_RD, 32'h1122_AB44, cyc + 1);
        tick();
        i_master_read_stb   = 1'b0;
        wait_drain(BUDGET);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL byte_enable_timeout: %0d acks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_console();
        int base_en;
        int r;
        i_console_ready = 1'b0;
        cons_q.delete();
        base_en = mem_en_cnt;
        for (int i = 0; i < 8; i++) begin
            i_master_write_addr = CONS;
            i_master_write_data = 32'h41 + i;
            i_master_write_sel  = 4'h1;
            i_master_write_stb  = 1'b1;
            expect_ack(GNT_WR, 32'h0, cyc + 1);
            tick();
            i_master_write_stb  = 1'b0;
            wait_drain(BUDGET);
        end
        // Status read while full reports 1.
        i_master_read_addr = CONS;
        i_master_read_stb  = 1'b1;
        expect_ack(GNT_RD, 32'h1, cyc + 1);
        tick();
        i_master_read_stb  = 1'b0;
        wait_drain(BUDGET);
        checks++;
        if (o_console_valid !== 1'b1 || o_console_data !== 8'h41) begin
            failures++;
            $display("FAIL console_head: valid=%b data=%h, required 1/41",
                     o_console_valid, o_console_data);
        end
        // Ninth write stalls, and the fetch behind it must not reach the SRAM.
        i_master_write_data = 32'h49;
        i_master_write_stb  = 1'b1;
        tick();
        i_master_write_stb  = 1'b0;
        i_inst_read_addr    = 32'h0001_0000;
        i_inst_read_stb     = 1'b1;
        tick();
        i_inst_read_stb     = 1'b0;
        repeat (6) tick();
        checks++;
        if (mem_en_cnt != base_en) begin
            failures++;
            $display("FAIL console_stall_mem_en: %0d SRAM cycles, required 0", mem_en_cnt - base_en);
        end
        r = cyc;
        i_console_ready = 1'b1;
        expect_ack(GNT_WR, 32'h0, r + 1);
        expect_ack(GNT_IF, 32'h0000_0013, r + 2);
        wait_drain(BUDGET);
        repeat (12) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL console_timeout: %0d acks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (cons_q.size() != 9) begin
            failures++;
            $display("FAIL console_count: %0d bytes, required 9", cons_q.size());
        end
        for (int i = 0; i < 9 && i < cons_q.size(); i++) begin
            checks++;
            if (cons_q[i] !== 8'(8'h41 + i)) begin
                failures++;
                $display("FAIL console_byte%0d: %h, required %h", i, cons_q[i], 8'(8'h41 + i));
            end
        end
        checks++;
        if (o_console_valid !== 1'b0 || mem_en_cnt != base_en + 1) begin
            failures++;
            $display("FAIL console_after: valid=%b sram_cycles=%0d, required 0/1",
                     o_console_valid, mem_en_cnt - base_en);
        end
        i_console_ready = 1'b0;
    endtask

    task automatic test_out_of_window();
        int base_en;
        sram[0] = 32'h5A5A_5A5A;
        base_en = mem_en_cnt;
        tick();
        i_master_read_addr = 32'h0004_0000;
        i_master_read_stb  = 1'b1;
        expect_ack(GNT_RD, 32'h0, cyc + 1);
        tick();
        i_master_read_stb  = 1'b0;
        wait_drain(BUDGET);
        i_master_write_addr = 32'h0004_0000;
        i_master_write_data = 32'hCAFE_F00D;
        i_master_write_sel  = 4'hF;
        i_master_write_stb  = 1'b1;
        expect_ack(GNT_WR, 32'h0, cyc + 1);
        tick();
        i_master_write_stb  = 1'b0;
        wait_drain(BUDGET);
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL oow_timeout: %0d acks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (mem_en_cnt != base_en) begin
            failures++;
            $display("FAIL oow_mem_en: %0d SRAM cycles, required 0", mem_en_cnt - base_en);
        end
        checks++;
        if (sram[0] !== 32'h5A5A_5A5A) begin
            failures++;
            $display("FAIL oow_sram: %h, required 5a5a5a5a", sram[0]);
        end
    endtask

    task automatic test_reset_midflight();
        int base_acks;
        i_console_ready = 1'b0;
        base_acks = ack_seen;
        i_master_write_addr = CONS;
        i_master_write_data = 32'h77;
        i_master_write_sel  = 4'h1;
        i_master_read_addr  = 32'h0001_0100;
        i_inst_read_addr    = 32'h0001_0000;
        i_master_write_stb  = 1'b1;
        i_master_read_stb   = 1'b1;
        i_inst_read_stb     = 1'b1;
        #2;
        i_reset = 1'b1;
        #1;
        i_master_write_stb  = 1'b0;
        i_master_read_stb   = 1'b0;
        i_inst_read_stb     = 1'b0;
        checks++;
        if ({o_master_write_ack, o_master_read_ack, o_inst_read_ack, o_mem_en} !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_outputs: acks/en=%b, required 0000",
                     {o_master_write_ack, o_master_read_ack, o_inst_read_ack, o_mem_en});
        end
        checks++;
        if (o_inst_read_data !== 32'h0 || o_master_read_data !== 32'h0) begin
            failures++;
            $display("FAIL midreset_data: if=%h rd=%h, required 0/0",
                     o_inst_read_data, o_master_read_data);
        end
        repeat (2) tick();
        #2;
        i_reset = 1'b0;
        repeat (8) tick();
        checks++;
        if (ack_seen != base_acks) begin
            failures++;
            $display("FAIL midreset_acks: %0d acks, required 0", ack_seen - base_acks);
        end
        checks++;
        if (o_console_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_fifo: valid=%b, required 0", o_console_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_byte_enable();
        test_console();
        test_out_of_window();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
